usb_desc_fetch: RTL
===================

USB_DESC_FETCH -- requirements
Module: usb_desc_fetch

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64, EP0 max packet size in bytes (8/16/32/64).
REQ-002 SHALL have port clk  in  1  sole clock.
REQ-003 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  in  1  one-cycle pulse marking a decoded GET_DESCRIPTOR setup.
REQ-005 SHALL have port req_type  in  8  wValue high byte, the descriptor type.
REQ-006 SHALL have port req_index  in  8  wValue low byte, the descriptor index.
REQ-007 SHALL have port req_length  in  16  wLength.
REQ-008 SHALL have port hs_mode  in  1  1 = high-speed link.
REQ-009 SHALL have ports desc_*_addr_i / desc_*_len_i  in  16 each  descriptor table from usb_desc, plus desc_have_strings_i  in  1.
REQ-010 SHALL have port descrom_raddr_o  out  16  ROM byte address.
REQ-011 SHALL have port descrom_rdata_i  in  8  ROM data, combinational from descrom_raddr_o.
REQ-012 SHALL have port in_token  in  1  pulse: host IN token on EP0.
REQ-013 SHALL have port in_ack  in  1  pulse: host ACKed last packet.
REQ-014 SHALL have port in_retry  in  1  pulse: last packet lost (timeout), resend.
REQ-015 SHALL have ports tx_data  out  8 / tx_valid  out  1 / tx_ready  in  1 / tx_last  out  1  byte stream to packet TX.
REQ-016 SHALL have port tx_zlp  out  1  one-cycle request for a zero-length DATA packet.
REQ-017 SHALL have ports stall_o  out  1 / busy_o  out  1.

Function
REQ-018 States: IDLE, LOOKUP, WAIT_IN, SEND, WAIT_ACK, STALL.
REQ-019 IDLE + req_valid -> LOOKUP; req_valid in any other state SHALL abort the transfer and restart at LOOKUP (new SETUP wins).
REQ-020 LOOKUP (1 cycle): type 01 dev, 06 qual, 02 cfg (hs_mode ? hscfg : fscfg), 0F BOS, 22 HID report, 03 string index 0..3 (index 0 length fixed 4); others, or strings with desc_have_strings_i=0 -> STALL.
REQ-021 Remaining count SHALL be min(req_length, descriptor length), 16-bit unsigned; base address loaded into descrom_raddr_o.
REQ-022 WAIT_IN + in_token -> SEND; tx_valid high in SEND only.
REQ-023 tx_data SHALL equal descrom_rdata_i; each tx_valid&tx_ready beat increments address and decrements remaining at that edge.
REQ-024 tx_last SHALL assert on the beat ending a packet: MAX_PKT-th byte of the packet or final remaining byte.
REQ-025 After tx_last beat -> WAIT_ACK; in_ack commits packet start = current address, then WAIT_IN if bytes remain or ZLP owed, else IDLE.
REQ-026 in_retry in WAIT_ACK SHALL rewind address and remaining to the committed packet start and return to WAIT_IN.
REQ-027 ZLP owed when total sent is a nonzero multiple of MAX_PKT and less than req_length; on in_token emit tx_zlp for one cycle, then WAIT_ACK.
REQ-028 Count of zero (req_length=0) SHALL go straight from LOOKUP to IDLE with no data.
REQ-029 STALL: stall_o high until next req_valid.
REQ-030 busy_o high in every state except IDLE and STALL.

Reset
REQ-031 On rstn low: state IDLE, descrom_raddr_o 0, remaining 0, tx_valid/tx_last/tx_zlp/stall_o/busy_o 0, immediately and asynchronously.
REQ-032 Reset mid-transfer SHALL discard all progress; no byte is emitted after release until a new req_valid.

Structure
REQ-033 Descriptor type codes, state enum and MAX_PKT default SHALL live in shared package usb_pkg.
REQ-034 Single module; no sub-module needed; instantiated beside usb_desc, driving its descrom_raddr_o.

Verification
REQ-035 Device desc, req_length=64: one 18-byte packet 12 01 00 02 ..., tx_last on byte 18, then IDLE after in_ack.
REQ-036 FS config, req_length=0x0200: packets 64,64,64,64,17 (273 bytes), addresses 28..300, tx_last on each packet end.
REQ-037 Config, req_length=9, hs_mode=1: 9 bytes from address 301, then IDLE.
REQ-038 Serial string (idx 3), MAX_PKT=8, req_length=28: packets 8,8,8,4; in_retry after 2nd packet resends identical 8 bytes.
REQ-039 MAX_PKT=8, req_length=64, 24-byte BOS: three 8-byte packets then tx_zlp on the fourth in_token.
REQ-040 req_type=0x05 -> stall_o=1, no tx_valid; rstn low during 2nd packet -> all outputs 0, no further bytes.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the EP0 descriptor fetch path.
// Contents: standard descriptor type codes, the fetch FSM state encoding,
// the default EP0 max packet size and a small unsigned min helper.
package usb_pkg;

    localparam int MAX_PKT_DEF = 64;

    localparam logic [7:0] DT_DEVICE     = 8'h01;
    localparam logic [7:0] DT_CONFIG     = 8'h02;
    localparam logic [7:0] DT_STRING     = 8'h03;
    localparam logic [7:0] DT_QUALIFIER  = 8'h06;
    localparam logic [7:0] DT_BOS        = 8'h0F;
    localparam logic [7:0] DT_HID_REPORT = 8'h22;

    // String descriptor 0 (language ID list) always holds one LANGID.
    localparam logic [15:0] STR0_LEN = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_IN,
        ST_SEND,
        ST_WAIT_ACK,
        ST_STALL
    } fetch_state_e;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_desc_fetch_if.sv
// Byte stream from the descriptor fetcher to the EP0 packet transmitter.
//   tx_data  : data byte (valid with tx_valid)
//   tx_valid : byte available
//   tx_ready : transmitter accepts the byte this cycle
//   tx_last  : byte closes the current DATA packet
//   tx_zlp   : one-cycle request for a zero-length DATA packet
interface usb_desc_fetch_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       tx_zlp;

    modport master (output tx_data, output tx_valid, output tx_last, output tx_zlp,
                    input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, input tx_zlp,
                    output tx_ready);
endinterface

// File: rtl/usb_desc_fetch.sv
// EP0 GET_DESCRIPTOR data stage engine. Resolves a decoded request against the
// descriptor table, walks the descriptor ROM and streams bytes to the packet
// transmitter in MAX_PKT-sized packets, handling host ACK, resend on timeout
// and the trailing zero-length packet.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   req_*, hs_mode                 decoded setup request, link speed
//   desc_*_addr_i / desc_*_len_i   descriptor table (ROM base / length)
//   descrom_raddr_o / _rdata_i     descriptor ROM read port (comb. data)
//   in_token, in_ack, in_retry     EP0 IN handshake events
//   tx                             byte stream to packet TX (master)
//   stall_o, busy_o                status
//
// state      | meaning
// IDLE       | no transfer pending
// LOOKUP     | resolve type/index to ROM base and length
// WAIT_IN    | packet ready, waiting for host IN token
// SEND       | streaming packet bytes
// WAIT_ACK   | packet sent, waiting for ACK or retry
// STALL      | unsupported request, stall until next setup
module usb_desc_fetch
    import usb_pkg::*;
#(
    parameter int MAX_PKT = MAX_PKT_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [7:0]  req_type,
    input  logic [7:0]  req_index,
    input  logic [15:0] req_length,
    input  logic        hs_mode,
    input  logic [15:0] desc_dev_addr_i,
    input  logic [15:0] desc_dev_len_i,
    input  logic [15:0] desc_qual_addr_i,
    input  logic [15:0] desc_qual_len_i,
    input  logic [15:0] desc_fscfg_addr_i,
    input  logic [15:0] desc_fscfg_len_i,
    input  logic [15:0] desc_hscfg_addr_i,
    input  logic [15:0] desc_hscfg_len_i,
    input  logic [15:0] desc_bos_addr_i,
    input  logic [15:0] desc_bos_len_i,
    input  logic [15:0] desc_hid_addr_i,
    input  logic [15:0] desc_hid_len_i,
    input  logic [15:0] desc_str0_addr_i,
    input  logic [15:0] desc_str1_addr_i,
    input  logic [15:0] desc_str1_len_i,
    input  logic [15:0] desc_str2_addr_i,
    input  logic [15:0] desc_str2_len_i,
    input  logic [15:0] desc_str3_addr_i,
    input  logic [15:0] desc_str3_len_i,
    input  logic        desc_have_strings_i,
    output logic [15:0] descrom_raddr_o,
    input  logic [7:0]  descrom_rdata_i,
    input  logic        in_token,
    input  logic        in_ack,
    input  logic        in_retry,
    usb_desc_fetch_if.master tx,
    output logic        stall_o,
    output logic        busy_o
);

    localparam int CW = $clog2(MAX_PKT) + 1;

    fetch_state_e  state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   rem_q, rem_d;
    logic [15:0]   pkt_addr_q, pkt_addr_d;
    logic [15:0]   pkt_rem_q, pkt_rem_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    type_q, type_d;
    logic [7:0]    index_q, index_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_full_q, last_full_d;
    logic          short_q, short_d;
    logic          zlp_q, zlp_d;

    logic          lk_ok;
    logic [15:0]   lk_addr, lk_len, lk_count;
    logic          beat, pkt_end;

    assign descrom_raddr_o = addr_q;
    assign tx.tx_data      = descrom_rdata_i;
    assign tx.tx_valid     = (state_q == ST_SEND);
    assign pkt_end         = (cnt_q == CW'(MAX_PKT - 1)) || (rem_q == 16'd1);
    assign tx.tx_last      = tx.tx_valid && pkt_end;
    assign tx.tx_zlp       = zlp_q;
    assign beat            = tx.tx_valid && tx.tx_ready;
    assign stall_o         = (state_q == ST_STALL);
    assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_STALL);
    assign lk_count        = min16(len_q, lk_len);

    always_comb begin
        lk_ok   = 1'b1;
        lk_addr = desc_dev_addr_i;
        lk_len  = desc_dev_len_i;
        case (type_q)
            DT_DEVICE: begin
                lk_addr = desc_dev_addr_i;
                lk_len  = desc_dev_len_i;
            end
            DT_QUALIFIER: begin
                lk_addr = desc_qual_addr_i;
                lk_len  = desc_qual_len_i;
            end
            DT_CONFIG: begin
                lk_addr = hs_mode ? desc_hscfg_addr_i : desc_fscfg_addr_i;
                lk_len  = hs_mode ? desc_hscfg_len_i  : desc_fscfg_len_i;
            end
            DT_BOS: begin
                lk_addr = desc_bos_addr_i;
                lk_len  = desc_bos_len_i;
            end
            DT_HID_REPORT: begin
                lk_addr = desc_hid_addr_i;
                lk_len  = desc_hid_len_i;
            end
            DT_STRING: begin
                lk_ok = desc_have_strings_i;
                case (index_q)
                    8'd0: begin lk_addr = desc_str0_addr_i; lk_len = STR0_LEN;        end
                    8'd1: begin lk_addr = desc_str1_addr_i; lk_len = desc_str1_len_i; end
                    8'd2: begin lk_addr = desc_str2_addr_i; lk_len = desc_str2_len_i; end
                    8'd3: begin lk_addr = desc_str3_addr_i; lk_len = desc_str3_len_i; end
                    default: lk_ok = 1'b0;
                endcase
            end
            default: lk_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        pkt_addr_d  = pkt_addr_q;
        pkt_rem_d   = pkt_rem_q;
        len_d       = len_q;
        type_d      = type_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        last_full_d = last_full_q;
        short_d     = short_q;
        zlp_d       = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_LOOKUP: begin
                if (!lk_ok) begin
                    state_d = ST_STALL;
                end else if (lk_count == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d     = lk_addr;
                    rem_d      = lk_count;
                    pkt_addr_d = lk_addr;
                    pkt_rem_d  = lk_count;
                    // Host asked for more than exists: a full final packet
                    // must be terminated with a ZLP.
                    short_d    = (lk_len < len_q);
                    state_d    = ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                if (in_token) begin
                    if (rem_q == 16'd0) begin
                        // Only reachable when a ZLP is owed.
                        zlp_d       = 1'b1;
                        last_full_d = 1'b0;
                        state_d     = ST_WAIT_ACK;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (beat) begin
                    addr_d = addr_q + 16'd1;
                    rem_d  = rem_q - 16'd1;
                    cnt_d  = cnt_q + CW'(1);
                    if (pkt_end) begin
                        last_full_d = (cnt_q == CW'(MAX_PKT - 1));
                        state_d     = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (in_retry) begin
                    addr_d  = pkt_addr_q;
                    rem_d   = pkt_rem_q;
                    state_d = ST_WAIT_IN;
                end else if (in_ack) begin
                    pkt_addr_d = addr_q;
                    pkt_rem_d  = rem_q;
                    if ((rem_q != 16'd0) || (last_full_q && short_q))
                        state_d = ST_WAIT_IN;
                    else
                        state_d = ST_IDLE;
                end
            end
            ST_STALL: ;
            default: state_d = ST_IDLE;
        endcase

        // A new SETUP always wins over whatever transfer is in flight.
        if (req_valid) begin
            type_d  = req_type;
            index_d = req_index;
            len_d   = req_length;
            state_d = ST_LOOKUP;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pkt_addr_q  <= '0;
            pkt_rem_q   <= '0;
            len_q       <= '0;
            type_q      <= '0;
            index_q     <= '0;
            cnt_q       <= '0;
            last_full_q <= 1'b0;
            short_q     <= 1'b0;
            zlp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pkt_addr_q  <= pkt_addr_d;
            pkt_rem_q   <= pkt_rem_d;
            len_q       <= len_d;
            type_q      <= type_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            last_full_q <= last_full_d;
            short_q     <= short_d;
            zlp_q       <= zlp_d;
        end
    end

endmodule
